// File: rtl/fphub_to_ieee_stream.sv
// fphub_to_ieee_stream: re-encodes FPHUB results as IEEE-754 words.
// Two-stage valid/ready pipeline with class, flags and inexact count.
module fphub_to_ieee_stream #(
  parameter int M      = 23,
  parameter int E      = 8,
  parameter int EXTEND = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [E+M:0]        in_data,
  input  logic                rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [E+M+EXTEND:0] out_data,
  output logic [1:0]          out_class,
  output logic                out_inexact,
  output logic                out_overflow,
  input  logic                cnt_clear,
  output logic [15:0]         inexact_count
);

  localparam int MO = M + EXTEND;
  localparam bit ROUND = (EXTEND == 0);
  localparam logic [E-1:0] EMAX = '1;
  localparam logic [MO-1:0] QNAN = {1'b1, {(MO-1){1'b0}}};

  typedef enum logic [1:0] {
    C_ZERO = 2'd0,
    C_NORM = 2'd1,
    C_INF  = 2'd2,
    C_NAN  = 2'd3
  } cls_t;

  logic         in_sign;
  logic [E-1:0] in_exp;
  logic [M-1:0] in_frac;
  cls_t         in_cls;
  logic         in_inc;

  assign {in_sign, in_exp, in_frac} = in_data;

  always_comb begin
    in_cls = C_NORM;
    if (in_exp == '0)
      in_cls = C_ZERO;
    else if (in_exp == EMAX)
      in_cls = (&in_frac) ? C_INF : C_NAN;
  end

  // HUB values are ties: RNE rounds up exactly when the kept LSB is odd
  assign in_inc = ROUND && (in_cls == C_NORM) && !rm && in_frac[0];

  logic         s1_valid;
  logic         s1_sign;
  logic         s1_inc;
  logic [E-1:0] s1_exp;
  logic [M-1:0] s1_frac;
  cls_t         s1_cls;
  logic         s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_inc   <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_cls   <= C_ZERO;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_inc  <= in_inc;
        s1_exp  <= in_exp;
        s1_frac <= in_frac;
        s1_cls  <= in_cls;
      end
    end
  end

  logic [M:0]    sum;
  logic [E-1:0]  exp_r;
  logic          ovf;
  logic [MO-1:0] frac_n;

  assign sum   = {1'b0, s1_frac} + {{M{1'b0}}, s1_inc};
  assign exp_r = s1_exp + {{(E-1){1'b0}}, sum[M]};
  assign ovf   = sum[M] && (exp_r == EMAX);

  generate
    if (EXTEND == 1) begin : g_ext
      assign frac_n = {s1_frac, 1'b1};
    end else begin : g_rnd
      assign frac_n = sum[M-1:0];
    end
  endgenerate

  logic [E+MO:0] d_data;
  logic [1:0]    d_cls;
  logic          d_inex;
  logic          d_ovf;

  always_comb begin
    d_data = {s1_sign, exp_r, frac_n};
    d_cls  = C_NORM;
    d_inex = ROUND;
    d_ovf  = 1'b0;
    unique case (s1_cls)
      C_ZERO: begin
        d_data = {s1_sign, {E{1'b0}}, {MO{1'b0}}};
        d_cls  = C_ZERO;
        d_inex = 1'b0;
      end
      C_INF: begin
        d_data = {s1_sign, EMAX, {MO{1'b0}}};
        d_cls  = C_INF;
        d_inex = 1'b0;
      end
      C_NAN: begin
        d_data = {1'b0, EMAX, QNAN};
        d_cls  = C_NAN;
        d_inex = 1'b0;
      end
      C_NORM: begin
        if (ovf) begin
          d_data = {s1_sign, EMAX, {MO{1'b0}}};
          d_cls  = C_INF;
          d_ovf  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_class    <= 2'd0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= d_data;
        out_class    <= d_cls;
        out_inexact  <= d_inex;
        out_overflow <= d_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear)
      inexact_count <= '0;
    else if (out_valid && out_ready && out_inexact && !(&inexact_count))
      inexact_count <= inexact_count + 16'd1;
  end

endmodule

// File: tb/tb_fphub_to_ieee_stream.sv
// tb_fphub_to_ieee_stream: directed checks of the FPHUB->IEEE stream
// converter, rounded (EXTEND=0) and exact (EXTEND=1) builds side by side.
module tb_fphub_to_ieee_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        rm;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready, out_valid, out_inexact, out_overflow;
  logic [31:0] out_data;
  logic [1:0]  out_class;
  logic [15:0] inexact_count;

  logic        x_in_ready, x_out_valid, x_out_inexact, x_out_overflow;
  logic [32:0] x_out_data;
  logic [1:0]  x_out_class;
  logic [15:0] x_inexact_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fphub_to_ieee_stream #(.M(23), .E(8), .EXTEND(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class),
    .out_inexact(out_inexact), .out_overflow(out_overflow),
    .cnt_clear(cnt_clear), .inexact_count(inexact_count)
  );

  fphub_to_ieee_stream #(.M(23), .E(8), .EXTEND(1)) dut_x (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(x_in_ready),
    .in_data(in_data), .rm(rm),
    .out_valid(x_out_valid), .out_ready(out_ready),
    .out_data(x_out_data), .out_class(x_out_class),
    .out_inexact(x_out_inexact), .out_overflow(x_out_overflow),
    .cnt_clear(cnt_clear), .inexact_count(x_inexact_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rounded golden for normal inputs: treat {exp,frac} as one integer,
  // bump it on RNE+odd, clamp to inf if the exponent fills up.
  function automatic logic [31:0] gold0(input logic [31:0] d,
                                        input logic r);
    logic [30:0] mag;
    mag = d[30:0];
    if (!r && d[0]) mag = mag + 31'd1;
    if (mag[30:23] == 8'hFF) mag = {8'hFF, 23'h0};
    return {d[31], mag};
  endfunction

  // Exact-build golden: {class, 33-bit word}
  function automatic logic [34:0] goldx(input logic [31:0] d);
    logic [22:0] f;
    f = d[22:0];
    if (d[30:23] == 8'h00) return {2'd0, d[31], 32'h0};
    if (d[30:23] == 8'hFF) begin
      if (&f) return {2'd2, d[31], 8'hFF, 24'h0};
      return {2'd3, 1'b0, 8'hFF, 24'h800000};
    end
    return {2'd1, d, 1'b1};
  endfunction

  task automatic beat(input logic [31:0] d, input logic r,
                      input logic [31:0] ed, input logic [1:0] ec,
                      input logic ei, input logic eo, input string tag);
    logic [34:0] gx;
    gx = goldx(d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; rm = r; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "/lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "/valid"}, out_valid, 1'b1);
    chk({tag, "/data"}, out_data, ed);
    chk({tag, "/class"}, out_class, ec);
    chk({tag, "/inexact"}, out_inexact, ei);
    chk({tag, "/overflow"}, out_overflow, eo);
    chk({tag, "/x_data"}, x_out_data, gx[32:0]);
    chk({tag, "/x_class"}, x_out_class, gx[34:33]);
    chk({tag, "/x_inexact"}, x_out_inexact, 1'b0);
  endtask

  logic [31:0] bp_vec [8];
  logic        bp_rm  [8];
  logic        pat    [4];

  initial begin
    logic [31:0] d, ed;
    logic        hs_in, hs_out, prev_hold;
    logic [36:0] held;
    int sent, recv, cyc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; rm = 1'b0;
    out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst/out_valid", out_valid, 1'b0);
    chk("rst/out_data", out_data, 32'h0);
    chk("rst/out_class", out_class, 2'd0);
    chk("rst/inexact", out_inexact, 1'b0);
    chk("rst/overflow", out_overflow, 1'b0);
    chk("rst/count", inexact_count, 16'h0);
    chk("rst/in_ready", in_ready, 1'b1);
    chk("rst/x_out_data", x_out_data, 33'h0);

    beat(32'h3F800000, 0, 32'h3F800000, 2'd1, 1, 0, "rne_even");
    beat(32'h3F800001, 0, 32'h3F800002, 2'd1, 1, 0, "rne_odd");
    beat(32'h3FFFFFFF, 0, 32'h40000000, 2'd1, 1, 0, "rne_carry");
    beat(32'h3F800001, 1, 32'h3F800001, 2'd1, 1, 0, "rtz_odd");
    beat(32'h7F7FFFFF, 0, 32'h7F800000, 2'd2, 1, 1, "ovf_rne");
    beat(32'h7F7FFFFF, 1, 32'h7F7FFFFF, 2'd1, 1, 0, "ovf_rtz");
    beat(32'h80000123, 0, 32'h80000000, 2'd0, 0, 0, "zero");
    beat(32'hFFFFFFFF, 0, 32'hFF800000, 2'd2, 0, 0, "inf");
    beat(32'h7F800005, 0, 32'h7FC00000, 2'd3, 0, 0, "nan");
    chk("x/one", x_out_data, {1'b0, 8'hFF, 24'h800000});
    beat(32'h3F800000, 0, 32'h3F800000, 2'd1, 1, 0, "x_one");
    chk("x/one_word", x_out_data, {1'b0, 8'h7F, 24'h000001});

    for (int i = 0; i < 10; i++) begin
      d = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)),
           23'($urandom)};
      ed = gold0(d, 1'b0);
      beat(d, 0, ed, (ed[30:23] == 8'hFF) ? 2'd2 : 2'd1, 1,
           ed[30:23] == 8'hFF, "rand");
    end

    // backpressure: out_ready cycles 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bp_vec[i] = 32'h3F800000 + 32'(i * 3) + 32'(i << 23);
      bp_rm[i]  = i[1];
    end
    @(posedge clk); #1;
    sent = 0; recv = 0; cyc = 0; prev_hold = 1'b0; held = '0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = bp_vec[sent % 8];
      rm        = bp_rm[sent % 8];
      #1;
      chk("bp/in_ready", in_ready, !((sent - recv) == 2 && !out_ready));
      if (prev_hold)
        chk("bp/stable", {out_valid, out_data, out_class, out_inexact,
                          out_overflow}, held);
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        chk("bp/data", out_data, gold0(bp_vec[recv], bp_rm[recv]));
        recv++;
      end
      prev_hold = out_valid && !out_ready;
      held = {out_valid, out_data, out_class, out_inexact, out_overflow};
      if (hs_in) sent++;
      cyc++;
    end
    chk("bp/no_timeout", cyc < 200, 1'b1);
    chk("bp/sent", sent, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp/drained", out_valid, 1'b0);

    // saturating counter
    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    in_valid = 1'b1; in_data = 32'h3F800000; rm = 1'b0; out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt/saturate", inexact_count, 16'hFFFF);
    chk("cnt/x_exact", x_inexact_count, 16'h0);

    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h3F800000; rm = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr/pending", out_valid && out_inexact, 1'b1);
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clr/count", inexact_count, 16'h0);
    chk("clr/accepted", out_valid, 1'b0);

    beat(32'h3F800000, 0, 32'h3F800000, 2'd1, 1, 0, "cnt_inc");
    @(posedge clk); #1;
    chk("cnt/one", inexact_count, 16'h1);

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3F800001; rm = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h40000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full/in_ready", in_ready, 1'b0);
    chk("full/out_data", out_data, 32'h3F800002);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst/out_valid", out_valid, 1'b0);
    chk("mid_rst/out_data", out_data, 32'h0);
    chk("mid_rst/count", inexact_count, 16'h0);
    chk("mid_rst/in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst/ignored", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
